instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Reader side of the instruction memory. Owns the program counter, drives the
//   6-bit fetch address, captures the 32-bit combinational instruction word, and
//   presents it to decode over a valid/ready handshake. Sits between
//   Instruction_Mem and the decode stage. Handles stall, branch redirect and
//   end-of-program halt.
// PARAMETERS
//   ADDR_W        6      PC / memory address width (64 words)
//   INSTR_W       32     instruction width
//   RESET_PC      0      PC value loaded on reset
//   HALT_ON_ZERO  1      1: an all-zero fetched word stops fetch (HALT state)
// PORTS
//   clk            in   1        rising-edge clock
//   rst            in   1        synchronous, active-high reset
//   pc_addr        out  ADDR_W   address to instruction memory (= PC register)
//   instr_in       in   INSTR_W  word from memory; valid in the same cycle as pc_addr
//   redirect       in   1        branch/jump taken; highest priority
//   redirect_pc    in   ADDR_W   target PC when redirect=1
//   if_valid       out  1        if_instr/if_pc hold a valid fetched instruction
//   if_ready       in   1        decode accepts when if_valid & if_ready
//   if_instr       out  INSTR_W  registered instruction
//   if_pc          out  ADDR_W   address if_instr was fetched from
//   halted         out  1        1 while in HALT state
// BEHAVIOUR
//   Reset (rst=1 at posedge): PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0,
//     halted=0, state=FETCH. Reset mid-handshake drops the held word.
//   States: FETCH, HALT.
//   Slot free = !if_valid | if_ready (output register empty or drained this cycle).
//   FETCH, no redirect, slot free, word non-halt: if_instr<=instr_in,
//     if_pc<=PC, if_valid<=1, PC<=PC+1 (mod 2^ADDR_W; 63 wraps to 0).
//   FETCH, slot not free (stall): PC, if_instr, if_pc, if_valid all hold.
//   FETCH, slot free, HALT_ON_ZERO=1 and instr_in==0: word not issued,
//     if_valid<=0, PC holds, state<=HALT, halted<=1.
//   HALT: no fetch, if_valid=0, PC holds; leave only via redirect or rst.
//   redirect=1 (any state, overrides stall and halt): PC<=redirect_pc,
//     if_valid<=0 (flush, incl. un-accepted word), state<=FETCH, halted<=0.
//     First instruction from target appears at if_* one cycle later
//     (latency redirect -> if_valid = 2 clocks).
//   Steady-state latency: pc_addr -> if_valid = 1 clock; throughput 1 instr/clk
//     while if_ready=1.
//   if_instr/if_pc stable while if_valid=1 and if_ready=0.
//   Simultaneous redirect and accept: accept completes, then flush applies.
//   pc_addr is a pure register output (no combinational path from inputs).
// STRUCTURE
//   Package ifu_pkg: ADDR_W, INSTR_W, HALT_WORD (32'h0), state enum
//     {FETCH, HALT}, shared with decode and Instruction_Mem.
//   One sub-module: ifu_out_reg - single valid/ready pipeline register
//     (data+pc, flush input). PC, next-PC mux and FSM stay in the top.
// TESTING
//   Memory model: word0=32'h00200003, word1=32'h00400002, word2=32'h10640022,
//     rest 0.
//   1 Reset then if_ready=1 -> if_pc 0,1,2 on consecutive clocks with the above
//     words; clock 4: halted=1, if_valid=0, pc_addr=3.
//   2 if_ready=0 for 3 clocks while if_valid=1 at if_pc=1 -> if_instr stays
//     32'h00400002, pc_addr stays 2; release -> if_pc=2 next clock.
//   3 In HALT, redirect=1 redirect_pc=0 -> halted=0 next clock, if_pc=0 with
//     32'h00200003 one clock after that.
//   4 redirect to 1 while if_valid=1 and if_ready=0 -> held word dropped, next
//     valid word is if_pc=1.
//   5 HALT_ON_ZERO=0, memory all non-zero, redirect to 62 -> if_pc 62,63,0,1
//     (wrap-around).
//   6 rst asserted mid-stream -> next clock if_valid=0, pc_addr=RESET_PC,
//     halted=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit, decode and Instruction_Mem.
package ifu_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 32;

  // An all-zero word marks end of program.
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } ifu_state_e;

  function automatic logic is_halt_word(input logic [INSTR_W-1:0] w);
    return w == HALT_WORD;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Bus bundle between the fetch unit, instruction memory, redirect source and decode.
// Handshake: decode takes if_instr/if_pc on a rising edge where if_valid & if_ready
// are both high; while if_valid=1 and if_ready=0 the fetch side keeps if_instr/if_pc
// unchanged; if_valid never depends combinationally on if_ready.
interface ifu_if;
  import ifu_pkg::*;

  logic [ADDR_W-1:0]  pc_addr;
  logic [INSTR_W-1:0] instr_in;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               halted;

  modport master (
    output pc_addr, if_valid, if_instr, if_pc, halted,
    input  instr_in, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  pc_addr, if_valid, if_instr, if_pc, halted,
    output instr_in, redirect, redirect_pc, if_ready
  );
endinterface

// File: rtl/ifu_out_reg.sv
// Single-entry valid/ready pipeline register holding the fetched word and its PC.
module ifu_out_reg
  import ifu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic               ready,
  input  logic [INSTR_W-1:0] in_data,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] data,
  output logic [ADDR_W-1:0]  pc,
  output logic               slot_free
);

  // Room for a new word when empty or being drained this cycle.
  assign slot_free = !valid || ready;

  // Flush wins over load; an accepted word with no replacement empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      pc    <= in_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, next-PC selection and FETCH/HALT control for instruction fetch.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter bit                HALT_ON_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  ifu_if.master      bus,
  output ifu_state_e state_dbg
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  ifu_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic               slot_free;
  logic               stop_word;
  logic               fetch_go;
  logic               halted_o;

  assign stop_word = HALT_ON_ZERO && is_halt_word(bus.instr_in);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state: redirect always returns to FETCH; a stop word with room halts.
  always_comb begin
    state_d = state_q;
    if (bus.redirect) begin
      state_d = FETCH;
    end else if (state_q == FETCH && slot_free && stop_word) begin
      state_d = HALT;
    end
  end

  // Outputs decoded from state: issue a word only in FETCH with room and no flush.
  always_comb begin
    fetch_go = 1'b0;
    halted_o = 1'b0;
    if (state_q == HALT) begin
      halted_o = 1'b1;
    end else if (!bus.redirect && slot_free && !stop_word) begin
      fetch_go = 1'b1;
    end
  end

  // Program counter: redirect target, else advance after each issued word (wraps).
  always_ff @(posedge clk) begin
    if (rst)               pc_q <= RESET_PC;
    else if (bus.redirect) pc_q <= bus.redirect_pc;
    else if (fetch_go)     pc_q <= pc_q + PC_ONE;
  end

  ifu_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (fetch_go),
    .flush     (bus.redirect),
    .ready     (bus.if_ready),
    .in_data   (bus.instr_in),
    .in_pc     (pc_q),
    .valid     (bus.if_valid),
    .data      (bus.if_instr),
    .pc        (bus.if_pc),
    .slot_free (slot_free)
  );

  assign bus.pc_addr = pc_q;
  assign bus.halted  = halted_o;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized phase checked
// against the expected program-order instruction stream.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  localparam int ENTRY_W = ADDR_W + INSTR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              if_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  // ---------------- memories ----------------
  // Program with end marker (DUT 1) and an endless non-zero program (DUT 2).
  function automatic logic [INSTR_W-1:0] mem1(input logic [ADDR_W-1:0] a);
    case (a)
      6'd0:    return 32'h00200003;
      6'd1:    return 32'h00400002;
      6'd2:    return 32'h10640022;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [INSTR_W-1:0] mem2(input logic [ADDR_W-1:0] a);
    return 32'h8000_0000 | ((32'(a) * 32'h0001_0101) ^ 32'h0F0F_0000);
  endfunction

  // ---------------- DUTs ----------------
  ifu_if b1 ();
  ifu_if b2 ();
  ifu_state_e st1, st2;

  assign b1.instr_in    = mem1(b1.pc_addr);
  assign b1.redirect    = redirect;
  assign b1.redirect_pc = redirect_pc;
  assign b1.if_ready    = if_ready;
  assign b2.instr_in    = mem2(b2.pc_addr);
  assign b2.redirect    = redirect;
  assign b2.redirect_pc = redirect_pc;
  assign b2.if_ready    = if_ready;

  instr_fetch_unit #(.RESET_PC(6'd0), .HALT_ON_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .state_dbg(st1));
  instr_fetch_unit #(.RESET_PC(6'd0), .HALT_ON_ZERO(1'b0)) dut2 (
    .clk(clk), .rst(rst), .bus(b2), .state_dbg(st2));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Expected accepted stream: {pc, instr} in program order from the last start point.
  logic [ENTRY_W-1:0] exp1_q[$];
  logic [ENTRY_W-1:0] exp2_q[$];
  logic [ADDR_W-1:0]  tail2;

  task automatic restart1(input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] a;
    exp1_q.delete();
    a = start;
    for (int i = 0; i < 64; i++) begin
      if (mem1(a) == 32'h0) break;
      exp1_q.push_back({a, mem1(a)});
      a = a + 6'd1;
    end
  endtask

  task automatic topup2();
    while (exp2_q.size() < 8) begin
      exp2_q.push_back({tail2, mem2(tail2)});
      tail2 = tail2 + 6'd1;
    end
  endtask

  task automatic restart2(input logic [ADDR_W-1:0] start);
    exp2_q.delete();
    tail2 = start;
    topup2();
  endtask

  // Compare presented words against stream head, retire on handshake, restart on redirect.
  task automatic score_cycle();
    if (b1.if_valid) begin
      if (exp1_q.size() == 0) check("sb1_unexpected_word", {26'd0, b1.if_pc, b1.if_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        check("sb1_word", {26'd0, b1.if_pc, b1.if_instr}, {26'd0, exp1_q[0]});
        if (if_ready) void'(exp1_q.pop_front());
      end
    end
    if (b2.if_valid) begin
      check("sb2_word", {26'd0, b2.if_pc, b2.if_instr}, {26'd0, exp2_q[0]});
      if (if_ready) void'(exp2_q.pop_front());
    end
    if (redirect) begin
      restart1(redirect_pc);
      restart2(redirect_pc);
    end
    topup2();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset, then free-running fetch to end of program
    rst = 1'b1; if_ready = 1'b1; redirect = 1'b0;
    tick(); tick();
    check("rst_valid",  64'(b1.if_valid), 64'd0);
    check("rst_pc",     64'(b1.pc_addr),  64'd0);
    check("rst_halted", 64'(b1.halted),   64'd0);
    check("rst_instr",  64'(b1.if_instr), 64'd0);
    check("rst_ifpc",   64'(b1.if_pc),    64'd0);
    check("rst_state",  64'(st1),         64'(FETCH));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_valid", 64'(b1.if_valid), 64'd1);
      check("t1_ifpc",  64'(b1.if_pc),    64'(i));
      check("t1_instr", 64'(b1.if_instr), 64'(mem1(6'(i))));
    end
    tick();
    check("t1_halted",  64'(b1.halted),   64'd1);
    check("t1_hvalid",  64'(b1.if_valid), 64'd0);
    check("t1_hpc",     64'(b1.pc_addr),  64'd3);
    check("t1_hstate",  64'(st1),         64'(HALT));
    tick();
    check("t1_stay_halted", 64'(b1.halted), 64'd1);
    check("t1_stay_pc",     64'(b1.pc_addr), 64'd3);

    // 3: redirect out of HALT
    redirect = 1'b1; redirect_pc = 6'd0;
    tick();
    check("t3_halted", 64'(b1.halted),   64'd0);
    check("t3_valid",  64'(b1.if_valid), 64'd0);
    check("t3_pc",     64'(b1.pc_addr),  64'd0);
    redirect = 1'b0;
    tick();
    check("t3_ifpc",  64'(b1.if_pc),    64'd0);
    check("t3_instr", 64'(b1.if_instr), 64'h00200003);
    check("t3_valid2", 64'(b1.if_valid), 64'd1);

    // 2: stall with word at pc 1
    tick();
    check("t2_ifpc_pre", 64'(b1.if_pc), 64'd1);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_valid", 64'(b1.if_valid), 64'd1);
      check("t2_hold_instr", 64'(b1.if_instr), 64'h00400002);
      check("t2_hold_ifpc",  64'(b1.if_pc),    64'd1);
      check("t2_hold_pc",    64'(b1.pc_addr),  64'd2);
    end
    if_ready = 1'b1;
    tick();
    check("t2_rel_ifpc",  64'(b1.if_pc),    64'd2);
    check("t2_rel_instr", 64'(b1.if_instr), 64'h10640022);

    // 4: redirect while a word is held un-accepted
    redirect = 1'b1; redirect_pc = 6'd0;
    tick();
    redirect = 1'b0;
    tick();
    check("t4_ifpc0", 64'(b1.if_pc), 64'd0);
    if_ready = 1'b0;
    tick();
    check("t4_held", {62'd0, b1.if_valid, 1'b0} | 64'(b1.if_pc), 64'd2);
    redirect = 1'b1; redirect_pc = 6'd1;
    tick();
    check("t4_flush_valid", 64'(b1.if_valid), 64'd0);
    check("t4_flush_pc",    64'(b1.pc_addr),  64'd1);
    redirect = 1'b0; if_ready = 1'b1;
    tick();
    check("t4_valid", 64'(b1.if_valid), 64'd1);
    check("t4_ifpc",  64'(b1.if_pc),    64'd1);
    check("t4_instr", 64'(b1.if_instr), 64'h00400002);

    // 5: no halt on zero, wrap-around from 62
    redirect = 1'b1; redirect_pc = 6'd62;
    tick();
    check("t5_flush", 64'(b2.if_valid), 64'd0);
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [ADDR_W-1:0] a;
      a = 6'(62 + i);
      tick();
      check("t5_valid", 64'(b2.if_valid), 64'd1);
      check("t5_ifpc",  64'(b2.if_pc),    64'(a));
      check("t5_instr", 64'(b2.if_instr), 64'(mem2(a)));
    end
    check("t5_state", 64'(st2), 64'(FETCH));

    // 6: reset mid-stream, including a held word
    if_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t6_valid2",  64'(b2.if_valid), 64'd0);
    check("t6_pc2",     64'(b2.pc_addr),  64'd0);
    check("t6_halted2", 64'(b2.halted),   64'd0);
    check("t6_valid1",  64'(b1.if_valid), 64'd0);
    check("t6_pc1",     64'(b1.pc_addr),  64'd0);
    check("t6_halted1", 64'(b1.halted),   64'd0);

    // Randomized phase: random backpressure and redirects against the stream model
    rst = 1'b0;
    restart1(6'd0);
    restart2(6'd0);
    for (int i = 0; i < 2000; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      score_cycle();
      tick();
    end
    redirect = 1'b0; if_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      score_cycle();
      tick();
    end
    check("end_halted1",  64'(b1.halted),       64'd1);
    check("end_q1_empty", 64'(exp1_q.size()),   64'd0);
    check("end_state1",   64'(st1),             64'(HALT));
    check("end_halted2",  64'(b2.halted),       64'd0);
    check("end_valid2",   64'(b2.if_valid),     64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
